// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Sequences a 5-stage RISC-V pipeline: load-use stalls, EX-resolved
//   redirects, data-memory wait freezes and the halt drain/stop sequence.
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   id_opcode/id_rs1/id_rs2    ID-stage instruction fields
//   ex_memread/ex_rd           load in EX and its destination
//   ex_redirect/ex_halt        EX-resolved redirect / halt in EX
//   mem_req/dmem_ready         data-memory access in MEM and its completion
//   pc_write/ifid_write        PC and IF/ID load enables
//   ifid_flush/idex_flush      bubble insertion into IF/ID and ID/EX
//   pipe_en                    load enable for ID/EX, EX/MEM, MEM/WB
//   halted                     core stopped
//   stall_cycles               saturating count of cycles with pc_write=0
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             ex_halt,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic rs1_used, rs2_used, load_use, mem_wait;

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (id_opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin rs1_used = 1'b1; rs2_used = 1'b1; end
      7'b0010011, 7'b0000011, 7'b1100111: rs1_used = 1'b1;
      default: ;
    endcase
  end

  // ex_rd==0 covers id_rsX==0 too: a match against x0 can never be a hazard.
  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((rs1_used && id_rs1 == ex_rd) || (rs2_used && id_rs2 == ex_rd));
  assign mem_wait = mem_req & ~dmem_ready;

  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_en    = 1'b0;
    halted     = 1'b0;
    state_d    = state_q;
    drain_d    = drain_q;
    if (reset) begin
      // clock bubbles into the pipe while reset is held
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pipe_en    = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_wait) begin
            // full freeze: everything holds
          end else if (ex_halt) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pipe_en    = 1'b1;
            state_d    = DRAIN;
            drain_d    = DW'(DRAIN_CYCLES);
          end else if (ex_redirect) begin
            // ID instruction is wrong-path, so a pending load-use is moot
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pipe_en    = 1'b1;
          end else if (load_use) begin
            idex_flush = 1'b1;
            pipe_en    = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            pipe_en    = 1'b1;
          end
        end
        DRAIN: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          pipe_en    = ~mem_wait;
          if (!mem_wait) begin
            drain_d = drain_q - DW'(1);
            if (drain_q == DW'(1)) state_d = HALTED;
          end
        end
        HALTED: halted = 1'b1;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_write && stall_q != {CNT_W{1'b1}}) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage RISC-V pipeline: decides each cycle whether PC/IF-ID advance, which stage registers are flushed, and when the core freezes.
- Handles load-use stalls, EX-resolved redirects (taken branch, jal, jalr), data-memory wait states, and the halt drain/stop sequence.
- Sits beside the decoder: consumes the ID-stage opcode and register fields plus EX/MEM status bits, and drives the enables/flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- DRAIN_CYCLES, 2, cycles spent retiring MEM/WB after halt reaches EX before HALTED.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_opcode  in  7  opcode of instruction in ID.
- id_rs1  in  5  rs1 field in ID.
- id_rs2  in  5  rs2 field in ID.
- ex_memread  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of instruction in EX.
- ex_redirect  in  1  EX resolved a taken branch, jal or jalr this cycle.
- ex_halt  in  1  instruction in EX is halt (opcode 7'b1111111).
- mem_req  in  1  instruction in MEM accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID cleared to bubble at next edge.
- idex_flush  out  1  ID/EX cleared to bubble at next edge.
- pipe_en  out  1  load enable for ID/EX, EX/MEM, MEM/WB.
- halted  out  1  core stopped.
- stall_cycles  out  CNT_W  count of cycles with pc_write=0 since reset, saturating.

Behaviour:
- FSM states: RUN, DRAIN, HALTED; state and counters update on the rising clk edge.
- Reset (sampled high at edge): state=RUN, drain count=0, stall_cycles=0, halted=0. While reset is high, outputs are forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pipe_en=1, so bubbles are clocked in. Reset mid-DRAIN or in HALTED returns to RUN.
- Use decode: rs1 is used for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111. rs2 is used for 0110011, 0100011, 1100011. A register number of 0 never creates a hazard.
- load_use = ex_memread & ex_rd!=0 & ((rs1 used & id_rs1==ex_rd) | (rs2 used & id_rs2==ex_rd)).
- mem_wait = mem_req & ~dmem_ready.
- Outputs are combinational from state and inputs. In RUN, conditions apply in this priority order:
  1. mem_wait: pc_write=0, ifid_write=0, pipe_en=0, no flushes. Full freeze, for any duration.
  2. ex_halt: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pipe_en=1. Next state is DRAIN with count=DRAIN_CYCLES.
  3. ex_redirect: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, pipe_en=1. Redirect beats load_use because the ID instruction is discarded.
  4. load_use: pc_write=0, ifid_write=0, idex_flush=1, pipe_en=1. This gives exactly a one-cycle bubble; next cycle the load is in MEM, so load_use is low.
  5. Otherwise: pc_write=1, ifid_write=1, pipe_en=1, no flushes.
- DRAIN: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1. pipe_en=~mem_wait, and the count decrements only when mem_wait=0. When count reaches 1 and decrements, the next state is HALTED.
- HALTED: pc_write=0, ifid_write=0, pipe_en=0, no flushes, halted=1. Ignores all inputs until reset.
- stall_cycles: increments by 1 each non-reset cycle with pc_write=0, including DRAIN and HALTED. Holds at 2^CNT_W-1.

Test Plan:
- Load-use: lw x5 in EX (ex_memread=1, ex_rd=5), add x6,x5,x1 in ID -> one cycle pc_write=0, ifid_write=0, idex_flush=1; next cycle all normal; stall_cycles=1.
- x0 and non-use filter: ex_rd=0 with id_rs1=0 -> no stall. id_opcode=0110111 (lui) with id_rs1 field==ex_rd=5 -> no stall.
- Redirect with load_use in the same cycle -> pc_write=1, ifid_flush=1, idex_flush=1, no stall; stall_cycles unchanged.
- Memory wait: mem_req=1, dmem_ready=0 for 3 cycles, coinciding with load_use -> pipe_en=0, pc_write=0 for 3 cycles, no flushes; load_use bubble taken afterwards; stall_cycles=4.
- Halt: ex_halt=1 in RUN -> 2 DRAIN cycles with flushes asserted, then halted=1, pipe_en=0. Stays halted for 20 cycles with random inputs; stall_cycles increments every cycle.
- Reset in DRAIN (after 1 drain cycle) -> next cycle state RUN, halted=0, stall_cycles=0; flushes asserted while reset is held.
